// File: rtl/gost_pkg.sv
// ============================================================================
// gost_pkg : shared constants, FSM encoding and key-schedule helper
// Rev 1.0
// ============================================================================
`default_nettype none

package gost_pkg;

  localparam int R_WIDTH     = 32;
  localparam int TDATA_WIDTH = 2 * R_WIDTH;
  localparam int KEY_WIDTH   = 8 * R_WIDTH;
  localparam int SHIFT_VAL   = 11;
  localparam int ROUNDS      = 32;
  localparam int CNT_WIDTH   = $clog2(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Decrypt order: K0..K7 once forward, then K7..K0 three times.
  function automatic logic [2:0] dec_key_idx(input logic [CNT_WIDTH-1:0] r);
    if (r[CNT_WIDTH-1:3] == '0) begin
      return r[2:0];
    end
    return 3'd7 - r[2:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gost_replacer.sv
// ============================================================================
// gost_replacer : 32-bit nibble-wise substitution (RFC 8891 pi tables)
// Rev 1.0
// ============================================================================
`default_nettype none

module gost_replacer (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  // Row i substitutes nibble i (bits 4i+3:4i).
  localparam int c_sbox [8][16] = '{
    '{12,  4,  6,  2, 10,  5, 11,  9, 14,  8, 13,  7,  0,  3, 15,  1},
    '{ 6,  8,  2,  3,  9, 10,  5, 12,  1, 14,  4,  7, 11, 13,  0, 15},
    '{11,  3,  5,  8,  2, 15, 10, 13, 14,  1,  7,  4, 12,  9,  6,  0},
    '{12,  8,  2,  1, 13,  4, 15,  6,  7,  0, 10,  5,  3, 14,  9, 11},
    '{ 7, 15,  5, 10,  8,  1,  6, 13,  0,  9,  3, 14, 11,  4,  2, 12},
    '{ 5, 13, 15,  6,  9,  2, 12, 10, 11,  7,  8,  1,  4,  3, 14,  0},
    '{ 8, 14,  2,  5,  6,  9,  1, 12, 15,  4, 11,  0, 13, 10,  3,  7},
    '{ 1,  7, 14, 13,  0,  5,  8,  3,  4, 15, 10,  6,  9, 12, 11,  2}
  };

  for (genvar i = 0; i < 8; i++) begin : g_nibble
    assign o_data[4*i +: 4] = 4'(c_sbox[i][i_data[4*i +: 4]]);
  end

endmodule

`default_nettype wire

// File: rtl/gost_round.sv
// ============================================================================
// gost_round : one combinational Magma Feistel round, shared by enc/dec cores
// Rev 1.0
// ============================================================================
`default_nettype none

module gost_round
  import gost_pkg::*;
(
  input  logic [TDATA_WIDTH-1:0] i_block,
  input  logic [R_WIDTH-1:0]     i_subkey,
  input  logic                   i_last,
  output logic [TDATA_WIDTH-1:0] o_block
);

  logic [R_WIDTH-1:0] w_a0;
  logic [R_WIDTH-1:0] w_a1;
  logic [R_WIDTH-1:0] w_sum;
  logic [R_WIDTH-1:0] w_sub;
  logic [R_WIDTH-1:0] w_f;
  logic [R_WIDTH-1:0] w_x;

  assign w_a0  = i_block[R_WIDTH-1:0];
  assign w_a1  = i_block[TDATA_WIDTH-1:R_WIDTH];
  assign w_sum = w_a0 + i_subkey;

  gost_replacer u_replacer (
    .i_data (w_sum),
    .o_data (w_sub)
  );

  assign w_f = (w_sub << SHIFT_VAL) | (w_sub >> (R_WIDTH - SHIFT_VAL));
  assign w_x = w_a1 ^ w_f;

  // The final round leaves the halves unswapped.
  assign o_block = i_last ? {w_x, w_a0} : {w_a0, w_x};

endmodule

`default_nettype wire

// File: rtl/gost_dec_core.sv
// ============================================================================
// gost_dec_core : iterative Magma block decryptor, one round per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module gost_dec_core
  import gost_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   ss_aresetn_i,
  input  logic [KEY_WIDTH-1:0]   key_i,
  input  logic                   ss_tvalid_i,
  input  logic [TDATA_WIDTH-1:0] ss_tdata_i,
  output logic                   ss_tready_o,
  output logic                   sm_aresetn_o,
  output logic                   sm_tvalid_o,
  output logic [TDATA_WIDTH-1:0] sm_tdata_o,
  input  logic                   sm_tready_i
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [TDATA_WIDTH-1:0] r_block;
  logic [KEY_WIDTH-1:0]   r_key;

  logic                   w_load;
  logic                   w_last;
  logic [2:0]             w_key_idx;
  logic [R_WIDTH-1:0]     w_subkeys [8];
  logic [R_WIDTH-1:0]     w_subkey;
  logic [TDATA_WIDTH-1:0] w_round_out;

  // K0 sits in the most significant word of the key.
  for (genvar i = 0; i < 8; i++) begin : g_subkey
    assign w_subkeys[i] = r_key[KEY_WIDTH-1-R_WIDTH*i -: R_WIDTH];
  end

  assign w_key_idx = dec_key_idx(r_cnt);
  assign w_subkey  = w_subkeys[w_key_idx];
  assign w_last    = (r_cnt == CNT_WIDTH'(ROUNDS - 1));

  gost_round u_round (
    .i_block  (r_block),
    .i_subkey (w_subkey),
    .i_last   (w_last),
    .o_block  (w_round_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    ss_tready_o = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        ss_tready_o = 1'b1;
        if (ss_tvalid_i) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Accepting in DONE lets a new block start as the old one leaves.
        ss_tready_o = sm_tready_i;
        if (sm_tready_i) begin
          w_load      = ss_tvalid_i;
          w_state_nxt = ss_tvalid_i ? RUN : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_block <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_block <= ss_tdata_i;
        r_key   <= key_i;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_block <= w_round_out;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign sm_aresetn_o = ss_aresetn_i;
  assign sm_tvalid_o  = (r_state == DONE);
  assign sm_tdata_o   = r_block;

endmodule

`default_nettype wire
